// File: rtl/arm_cpu_pkg.sv
// arm_cpu_pkg: shared word/index types and architectural constants for the register bank.
package arm_cpu_pkg;
    typedef logic [31:0] word_t;
    typedef logic [3:0] reg_idx_t;
    localparam reg_idx_t PC_IDX = 4'd15;
    localparam int PC_READ_OFFSET = 8;
endpackage

// File: rtl/register_bank_if.sv
// register_bank_if: decode read ports, writeback port, fetch PC and load-issue signals.
interface register_bank_if
    import arm_cpu_pkg::*;
#(
    parameter int DATA_W = 32
);
    reg_idx_t rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic rd_busy_a;
    reg_idx_t rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic rd_busy_b;
    logic wr_en;
    reg_idx_t wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic pc_advance;
    logic [DATA_W-1:0] pc_out;
    logic busy_set;
    reg_idx_t busy_addr;
    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, pc_advance, busy_set, busy_addr,
        input rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, pc_out
    );
    modport slave (
        input rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, pc_advance, busy_set, busy_addr,
        output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, pc_out
    );
endinterface

// File: rtl/load_scoreboard.sv
// load_scoreboard: one pending-load bit per register; a set beats a clear on the same index.
module load_scoreboard
    import arm_cpu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  reg_idx_t set_idx,
    input  logic clr,
    input  reg_idx_t clr_idx,
    output logic [N-1:0] busy
);
    logic [N-1:0] set_m, clr_m;
    assign set_m = {{(N-1){1'b0}}, set} << set_idx;
    assign clr_m = {{(N-1){1'b0}}, clr} << clr_idx;
    always_ff @(posedge clk)
        if (reset) busy <= '0;
        else busy <= (busy & ~clr_m) | set_m;
endmodule

// File: rtl/register_bank.sv
// register_bank: ARM r0-r14 plus PC (r15 reads PC+8) with a load scoreboard.
// Define REGISTER_BANK_FORWARD_EN to bypass same-cycle writeback data onto the read ports.
module register_bank
    import arm_cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int PC_STEP = 4
) (
    input logic clk,
    input logic reset,
    register_bank_if.slave bus
);
    logic [DATA_W-1:0] regs [NUM_REGS-1];
    logic [DATA_W-1:0] pc;
    logic [NUM_REGS-1:0] busy;
    logic fwd_a, fwd_b;
    load_scoreboard #(.N(NUM_REGS)) u_scoreboard (
        .clk(clk),
        .reset(reset),
        .set(bus.busy_set),
        .set_idx(bus.busy_addr),
        .clr(bus.wr_en),
        .clr_idx(bus.wr_addr),
        .busy(busy)
    );
    always_ff @(posedge clk)
        if (reset) for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
        else if (bus.wr_en && bus.wr_addr != PC_IDX) regs[bus.wr_addr] <= bus.wr_data;
    // A branch write to r15 overrides the sequential step.
    always_ff @(posedge clk)
        if (reset) pc <= PC_RESET;
        else if (bus.wr_en && bus.wr_addr == PC_IDX) pc <= bus.wr_data;
        else if (bus.pc_advance) pc <= pc + DATA_W'(PC_STEP);
`ifdef REGISTER_BANK_FORWARD_EN
    assign fwd_a = bus.wr_en && bus.wr_addr == bus.rd_addr_a && bus.wr_addr != PC_IDX;
    assign fwd_b = bus.wr_en && bus.wr_addr == bus.rd_addr_b && bus.wr_addr != PC_IDX;
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif
    assign bus.rd_data_a = fwd_a ? bus.wr_data
                         : bus.rd_addr_a == PC_IDX ? pc + DATA_W'(PC_READ_OFFSET)
                         : regs[bus.rd_addr_a];
    assign bus.rd_data_b = fwd_b ? bus.wr_data
                         : bus.rd_addr_b == PC_IDX ? pc + DATA_W'(PC_READ_OFFSET)
                         : regs[bus.rd_addr_b];
    assign bus.rd_busy_a = busy[bus.rd_addr_a] && !fwd_a;
    assign bus.rd_busy_b = busy[bus.rd_addr_b] && !fwd_b;
    assign bus.pc_out = pc;
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: table-driven cycle vectors with an expected-value queue for register_bank.
module tb_register_bank;
    import arm_cpu_pkg::*;
`ifdef REGISTER_BANK_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {
        logic rst, we;
        logic [3:0] wa;
        logic [31:0] wd;
        logic adv, bs;
        logic [3:0] ba, ra, rb;
        logic [31:0] ea;
        logic eba;
        logic [31:0] eb;
        logic ebb;
        logic [31:0] epc;
    } vec_t;
    typedef struct {
        int id;
        logic [31:0] ea;
        logic eba;
        logic [31:0] eb;
        logic ebb;
        logic [31:0] epc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    exp_t sb[$];
    register_bank_if #(.DATA_W(32)) bus();
    register_bank dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic vec_t v(input logic rst, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic adv, input logic bs, input logic [3:0] ba, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [31:0] ea, input logic eba,
                               input logic [31:0] eb, input logic ebb, input logic [31:0] epc);
        v = '{rst, we, wa, wd, adv, bs, ba, ra, rb, ea, eba, eb, ebb, epc};
    endfunction
    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
        end
    endtask
    task automatic drive(input vec_t x);
        reset = x.rst;
        bus.wr_en = x.we;
        bus.wr_addr = x.wa;
        bus.wr_data = x.wd;
        bus.pc_advance = x.adv;
        bus.busy_set = x.bs;
        bus.busy_addr = x.ba;
        bus.rd_addr_a = x.ra;
        bus.rd_addr_b = x.rb;
    endtask
    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", -1, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("rd_data_a", e.id, bus.rd_data_a, e.ea);
        chk("rd_busy_a", e.id, 32'(bus.rd_busy_a), 32'(e.eba));
        chk("rd_data_b", e.id, bus.rd_data_b, e.eb);
        chk("rd_busy_b", e.id, 32'(bus.rd_busy_b), 32'(e.ebb));
        chk("pc_out", e.id, bus.pc_out, e.epc);
    endtask
    initial begin
        // reset, reads, write visibility
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 32'h0, 1'b0, 32'h8, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd14, 4'd7, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 4'd3, 4'd15, FWD ? 32'hDEADBEEF : 32'h0, 1'b0, 32'h8, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0));
        // PC stepping and branch priority over pc_advance
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 32'hC, 1'b0, 32'h0, 1'b0, 32'h4));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 32'h10, 1'b0, 32'h0, 1'b0, 32'h8));
        vecs.push_back(v(1'b0, 1'b1, 4'd15, 32'h100, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 32'h14, 1'b0, 32'h0, 1'b0, 32'hC));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h108, 1'b0, 32'h0, 1'b0, 32'h100));
        // scoreboard set, set-wins, clear
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd5, 4'd5, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd3, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b1, 4'd5, 32'h11, 1'b0, 1'b1, 4'd5, 4'd5, 4'd0, FWD ? 32'h11 : 32'h0, !FWD, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd0, 32'h11, 1'b1, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b1, 4'd5, 32'h22, 1'b0, 1'b0, 4'd0, 4'd6, 4'd5, 32'h0, 1'b0, FWD ? 32'h22 : 32'h11, !FWD, 32'h100));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd0, 32'h22, 1'b0, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd9, 4'd9, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b1, 4'd9, 32'h99, 1'b0, 1'b1, 4'd6, 4'd9, 4'd6, FWD ? 32'h99 : 32'h0, !FWD, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd9, 4'd6, 32'h99, 1'b0, 32'h0, 1'b1, 32'h100));
        // PC wrap at 2^32
        vecs.push_back(v(1'b0, 1'b1, 4'd15, 32'hFFFFFFFC, 1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h108, 1'b0, 32'h0, 1'b0, 32'h100));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 32'h4, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFC));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0));
        // reset mid-operation drops pending loads and the same-cycle writeback
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b1, 4'd7, 32'h55, 1'b1, 1'b0, 4'd0, 4'd2, 4'd7, 32'h0, 1'b1, FWD ? 32'h55 : 32'h0, 1'b0, 32'h4));
        vecs.push_back(v(1'b1, 1'b1, 4'd2, 32'h77, 1'b1, 1'b0, 4'd0, 4'd7, 4'd2, 32'h55, 1'b0, FWD ? 32'h77 : 32'h0, !FWD, 32'h8));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd7, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd6, 4'd9, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(v(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd3, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        drive(v(1'b1, 1'b1, 4'd4, 32'hA5A5A5A5, 1'b1, 1'b1, 4'd4, 4'd4, 4'd15, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            #1;
            drive(vecs[i]);
            sb.push_back('{i, vecs[i].ea, vecs[i].eba, vecs[i].eb, vecs[i].ebb, vecs[i].epc});
            @(negedge clk);
            compare_front();
            @(posedge clk);
        end
        if (sb.size() != 0) chk("scoreboard_leftover", -1, 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
